// File: rtl/lfo_pkg.sv
// Shared constants and state type for the LFO-modulated delay line.
package lfo_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int LFO_W     = 14;
  localparam int FRAC_BITS = 8;
  localparam int D_W       = 24;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    RD0,
    RD1,
    MIX
  } mod_state_t;

endpackage

// File: rtl/mod_delay_ram.sv
// Circular delay-line storage: one write port, one registered read port.
// No reset on the array so the tools can map it onto block RAM.
module mod_delay_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Store the incoming sample at the write pointer.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // Read data appears one cycle after the address is presented.
  always_ff @(posedge clk_i) begin
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/lfo_mod_delay.sv
// LFO-modulated delay line (chorus/vibrato core).
// Each accepted sample is written to a circular buffer and one linearly
// interpolated sample is read back at BASE_DELAY plus the LFO offset.
// Optional build macro MOD_DELAY_DRYMIX_EN: output is the average of the
// dry and wet samples (chorus) instead of the wet sample alone (vibrato).
module lfo_mod_delay #(
  parameter int SAMPLE_W   = lfo_pkg::SAMPLE_W,
  parameter int LFO_W      = lfo_pkg::LFO_W,
  parameter int ADDR_W     = 11,
  parameter int BASE_DELAY = 882,
  parameter int MOD_SHIFT  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sampleValid_i,
  input  logic signed [LFO_W-1:0]    wave_i,
  input  logic                       newValFlag_i,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       sampleValid_o,
  output logic                       busy_o
);

  import lfo_pkg::*;

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PROD_W = SAMPLE_W + FRAC_BITS + 2;
  localparam logic signed [D_W-1:0] BASE_Q8 = D_W'(BASE_DELAY << FRAC_BITS);
  localparam logic signed [D_W-1:0] D_MIN   = D_W'(1 << FRAC_BITS);
  localparam logic signed [D_W-1:0] D_MAX   = D_W'((DEPTH - 2) << FRAC_BITS);

  mod_state_t state, nextState;

  logic                       accept;
  logic [ADDR_W-1:0]          wrPtr, a0, a1, dInt, rdAddr;
  logic [FRAC_BITS-1:0]       frac;
  logic signed [LFO_W-1:0]    waveReg, waveEff;
  logic signed [D_W-1:0]      dRaw, dClamp;
  logic signed [SAMPLE_W-1:0] dry, s0, rdData, wet, mixOut;
  logic signed [SAMPLE_W:0]   diff;
  logic signed [PROD_W-1:0]   prod, wetFull;
  logic                       unusedBits;

  assign accept  = (state == IDLE) && sampleValid_i;
  assign waveEff = newValFlag_i ? wave_i : waveReg;
  assign busy_o  = (state != IDLE);
  assign rdAddr  = (state == RD1) ? a1 : a0;

  mod_delay_ram #(
    .DATA_W (SAMPLE_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .wrEn   (accept),
    .wrAddr (wrPtr),
    .wrData (sample_i),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  // Q.8 delay from the (possibly just-updated) wave, clamped to the usable buffer span.
  always_comb begin
    dRaw   = BASE_Q8 + (D_W'(waveEff) <<< MOD_SHIFT);
    dClamp = dRaw;
    if (dRaw < D_MIN)      dClamp = D_MIN;
    else if (dRaw > D_MAX) dClamp = D_MAX;
  end

  // Linear interpolation between the two taps; s1 is read straight off the RAM port.
  always_comb begin
    diff    = (SAMPLE_W+1)'(rdData) - (SAMPLE_W+1)'(s0);
    prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    wetFull = PROD_W'(s0) + (prod >>> FRAC_BITS);
    wet     = wetFull[SAMPLE_W-1:0];
  end

`ifdef MOD_DELAY_DRYMIX_EN
  logic signed [SAMPLE_W:0] mixSum;

  // Chorus: average the dry input with the delayed tap.
  always_comb begin
    mixSum = (SAMPLE_W+1)'(dry) + (SAMPLE_W+1)'(wet);
    mixOut = mixSum[SAMPLE_W:1];
  end

  assign unusedBits = ^{dClamp[D_W-1:FRAC_BITS+ADDR_W], wetFull[PROD_W-1:SAMPLE_W], mixSum[0]};
`else
  assign mixOut     = wet;
  assign unusedBits = ^{dClamp[D_W-1:FRAC_BITS+ADDR_W], wetFull[PROD_W-1:SAMPLE_W], dry};
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nextState;
  end

  // Fixed single-cycle walk through the read/interpolate sequence.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (sampleValid_i) nextState = CALC;
      CALC:    nextState = RD0;
      RD0:     nextState = RD1;
      RD1:     nextState = MIX;
      MIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // LFO latch, delay/dry capture, tap addresses, pointer advance and first tap capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      waveReg <= '0;
      wrPtr   <= '0;
      dInt    <= '0;
      frac    <= '0;
      dry     <= '0;
      a0      <= '0;
      a1      <= '0;
      s0      <= '0;
    end else begin
      if (newValFlag_i) waveReg <= wave_i;
      if (accept) begin
        dInt <= dClamp[FRAC_BITS +: ADDR_W];
        frac <= dClamp[FRAC_BITS-1:0];
        dry  <= sample_i;
      end
      if (state == CALC) begin
        a0    <= wrPtr - dInt;
        a1    <= wrPtr - dInt - 1'b1;
        wrPtr <= wrPtr + 1'b1;
      end
      if (state == RD1) s0 <= rdData;
    end
  end

  // Registered output, held between results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_o      <= '0;
      sampleValid_o <= 1'b0;
    end else begin
      sampleValid_o <= (state == MIX);
      if (state == MIX) sample_o <= mixOut;
    end
  end

endmodule
